sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single external 8-bit async SRAM (sramA/sramDQ/sramWe/sramOe) between two
//  requesters: port A = Oric core RAM bus (64 KB, 16-bit addr), port B = disk-image
//  buffer/DMA engine (full 21-bit addr). Sequences each access as a fixed-length
//  SRAM cycle, returns read data, pulses ack. Sits between core/FDC logic and top-level pins.
// PARAMETERS
//  ACCESS_CYCLES  3         SRAM strobe cycles per access; legal 2..15
//  A_BASE         21'h0     21-bit base added to port A address (A window in SRAM)
// PORTS
//  clk_sys     in   1   system clock; all logic on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  a_req       in   1   port A request (level, held until a_ack)
//  a_we        in   1   port A 1=write 0=read
//  a_addr      in   16  port A address
//  a_din       in   8   port A write data
//  a_dout      out  8   port A read data, valid when a_ack=1, held until next A read
//  a_ack       out  1   port A one-cycle completion pulse
//  b_req       in   1   port B request (level, held until b_ack)
//  b_we        in   1   port B 1=write 0=read
//  b_addr      in   21  port B address
//  b_din       in   8   port B write data
//  b_dout      out  8   port B read data, valid when b_ack=1, held until next B read
//  b_ack       out  1   port B one-cycle completion pulse
//  sram_a      out  21  SRAM address
//  sram_dq_o   out  8   SRAM write data
//  sram_dq_oe  out  1   1 = drive sram_dq_o onto pins
//  sram_dq_i   in   8   SRAM read data from pins
//  sram_we_n   out  1   SRAM write enable, active low
//  sram_oe_n   out  1   SRAM output enable, active low
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; sram_we_n=1, sram_oe_n=1, sram_dq_oe=0,
//   sram_a=0, sram_dq_o=0, a_ack=b_ack=0, a_dout=b_dout=0, last-grant=B.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: if any req, grant one (fixed priority A>B unless macro below); latch
//   addr/we/din of winner; sram_a <= A: A_BASE + {5'b0,a_addr} (mod 2^21), B: b_addr.
//   Go ACCESS, cycle counter=0. No req: stay IDLE, strobes inactive.
//  ACCESS (exactly ACCESS_CYCLES cycles, counter 0..ACCESS_CYCLES-1):
//   read : sram_oe_n=0 all cycles, sram_dq_oe=0; sram_dq_i sampled on final cycle.
//   write: sram_dq_oe=1 all cycles; sram_we_n=0 on all but final cycle (hold cycle).
//   sram_a/sram_dq_o stable throughout.
//  DONE (1 cycle): all strobes inactive (turnaround); winner's ack=1; read data on
//   winner's dout. Loser's ack stays 0. Next cycle IDLE.
//  Latency: req seen in IDLE cycle T -> ack in cycle T+ACCESS_CYCLES+1; throughput one
//   access per ACCESS_CYCLES+2 cycles. A requester keeping req high after ack starts a
//   new access (new addr/data sampled at next IDLE).
//  Req changes while not granted are ignored until IDLE; req dropped mid-access does
//   not abort it (ack still pulses).
//  Never both acks high; never we_n and oe_n low together; dq_oe=0 whenever oe_n=0.
//  Fixed priority: continuous A requests starve B (accepted; Oric bus idles per phi2).
//  Counter 4 bits; no wrap beyond ACCESS_CYCLES-1.
// CONFIGURATION
//  SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous a_req & b_req in IDLE, grant the
//   port NOT granted last; single requester always granted. Last-grant updates on grant.
//  Undefined: fixed priority A over B; last-grant register absent.
// TESTING
//  A read, ACCESS_CYCLES=3, a_addr=16'h1234, SRAM model 8'h5A -> sram_a=21'h001234,
//   oe_n low 3 cycles, a_ack at T+4, a_dout=8'h5A.
//  B write b_addr=21'h1F0000, b_din=8'hC3 -> dq_oe 3 cycles, we_n low 2 cycles,
//   model holds 8'hC3 at 21'h1F0000, b_ack at T+4, a_ack never.
//  a_req&b_req same cycle (macro off), 4 accesses -> A,A,A,A granted; macro on -> A,B,A,B.
//  A_BASE=21'h100000, a_addr=16'hFFFF -> sram_a=21'h10FFFF.
//  reset_n low during ACCESS write -> we_n=1, dq_oe=0 same cycle (async), no ack;
//   after release first req completes normally.
//  Back-to-back A reads held req -> acks spaced exactly ACCESS_CYCLES+2 cycles.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one 8-bit async SRAM; fixed-length strobe sequence per access.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module sram_port_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 3,
   parameter logic [20:0] A_BASE        = 21'h0
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [15:0] a_addr,
   input  logic [7:0]  a_din,
   output logic [7:0]  a_dout,
   output logic        a_ack,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [20:0] b_addr,
   input  logic [7:0]  b_din,
   output logic [7:0]  b_dout,
   output logic        b_ack,
   output logic [20:0] sram_a,
   output logic [7:0]  sram_dq_o,
   output logic        sram_dq_oe,
   input  logic [7:0]  sram_dq_i,
   output logic        sram_we_n,
   output logic        sram_oe_n
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

   localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       gnt_a_q;
   logic       we_q;
   logic       grant_any;
   logic       grant_a;
   logic       start;
   logic       last_cycle;

   assign grant_any  = a_req | b_req;
   assign start      = (state_q == StIdle) && grant_any;
   assign last_cycle = (state_q == StAccess) && (cnt_q == LastCnt);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_a_q;

   // On a tie, hand the bus to whichever port did not win last time.
   assign grant_a = a_req & (~b_req | ~last_a_q);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         last_a_q <= 1'b0;
      end else if (start) begin
         last_a_q <= grant_a;
      end
   end
`else
   assign grant_a = a_req;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant_any) begin
               state_d = StAccess;
               cnt_d   = 4'd0;
            end
         end
         StAccess: begin
            if (cnt_q == LastCnt) state_d = StDone;
            else                  cnt_d   = cnt_q + 4'd1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         gnt_a_q   <= 1'b0;
         we_q      <= 1'b0;
         sram_a    <= 21'h0;
         sram_dq_o <= 8'h00;
         a_dout    <= 8'h00;
         b_dout    <= 8'h00;
      end else begin
         if (start) begin
            gnt_a_q   <= grant_a;
            we_q      <= grant_a ? a_we : b_we;
            sram_a    <= grant_a ? (A_BASE + {5'b0, a_addr}) : b_addr;
            sram_dq_o <= grant_a ? a_din : b_din;
         end
         if (last_cycle && !we_q) begin
            if (gnt_a_q) a_dout <= sram_dq_i;
            else         b_dout <= sram_dq_i;
         end
      end
   end

   // Strobes decode straight from state so an async reset drops them immediately.
   always_comb begin
      sram_oe_n  = !((state_q == StAccess) && !we_q);
      sram_dq_oe = (state_q == StAccess) && we_q;
      sram_we_n  = !((state_q == StAccess) && we_q && (cnt_q != LastCnt));
      a_ack      = (state_q == StDone) && gnt_a_q;
      b_ack      = (state_q == StDone) && !gnt_a_q;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-level model with per-cycle compare plus directed
// literal checks. Honors SRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_sram_port_arbiter;

   localparam int unsigned AC = 3;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [15:0] a_addr = 16'h0;
   logic [7:0]  a_din = 8'h0, b_din = 8'h0;
   logic [20:0] b_addr = 21'h0;
   logic [7:0]  a_dout, b_dout, sram_dq_o, sram_dq_i;
   logic        a_ack, b_ack, sram_dq_oe, sram_we_n, sram_oe_n;
   logic [20:0] sram_a;

   logic [7:0]  d2_a_dout, d2_b_dout, d2_sram_dq_o;
   logic        d2_a_ack, d2_b_ack, d2_sram_dq_oe, d2_sram_we_n, d2_sram_oe_n;
   logic [20:0] d2_sram_a;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sram_port_arbiter #(.ACCESS_CYCLES(AC), .A_BASE(21'h0)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout), .b_ack(b_ack),
      .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   sram_port_arbiter #(.ACCESS_CYCLES(AC), .A_BASE(21'h100000)) dut2 (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_dout(d2_a_dout), .a_ack(d2_a_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_dout(d2_b_dout), .b_ack(d2_b_ack),
      .sram_a(d2_sram_a), .sram_dq_o(d2_sram_dq_o), .sram_dq_oe(d2_sram_dq_oe),
      .sram_dq_i(8'h00), .sram_we_n(d2_sram_we_n), .sram_oe_n(d2_sram_oe_n)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Async SRAM: write committed mid-cycle while we_n is low, read data follows address.
   logic [7:0] smem [logic [20:0]];
   initial begin
      sram_dq_i = 8'h00;
      smem[21'h001234] = 8'h5A;
      smem[21'h00FFFF] = 8'h77;
      smem[21'h000042] = 8'h99;
      smem[21'h000010] = 8'hA1;
      smem[21'h000020] = 8'hB2;
      forever begin
         @(negedge clk_sys);
         if (!sram_we_n) smem[sram_a] = sram_dq_o;
         sram_dq_i = smem.exists(sram_a) ? smem[sram_a] : 8'h00;
      end
   end

   // Transaction model: ph 0 idle, 1..AC access cycles, AC+1 done cycle.
   logic [7:0]  mmem [logic [20:0]];
   int          ph = 0;
   bit          win_a = 1'b0, m_we = 1'b0, last_a = 1'b0;
   logic [20:0] m_addr = 21'h0;
   logic [7:0]  m_din = 8'h0, e_a_dout = 8'h0, e_b_dout = 8'h0;

   function automatic logic [7:0] mrd(input logic [20:0] a);
      return mmem.exists(a) ? mmem[a] : 8'h00;
   endfunction

   initial begin
      bit acc, done;
      mmem[21'h001234] = 8'h5A;
      mmem[21'h00FFFF] = 8'h77;
      mmem[21'h000042] = 8'h99;
      mmem[21'h000010] = 8'hA1;
      mmem[21'h000020] = 8'hB2;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            ph = 0; m_addr = 21'h0; e_a_dout = 8'h0; e_b_dout = 8'h0; last_a = 1'b0;
         end
         acc  = (ph >= 1) && (ph <= AC);
         done = (ph == AC + 1);
         chk("m_oe_n", 32'(sram_oe_n), 32'(!(acc && !m_we)));
         chk("m_dq_oe", 32'(sram_dq_oe), 32'(acc && m_we));
         chk("m_we_n", 32'(sram_we_n), 32'(!(acc && m_we && ph != AC)));
         chk("m_a_ack", 32'(a_ack), 32'(done && win_a));
         chk("m_b_ack", 32'(b_ack), 32'(done && !win_a));
         chk("m_sram_a", 32'(sram_a), 32'(m_addr));
         chk("m_a_dout", 32'(a_dout), 32'(e_a_dout));
         chk("m_b_dout", 32'(b_dout), 32'(e_b_dout));
         if (acc && m_we) chk("m_dq_o", 32'(sram_dq_o), 32'(m_din));
         if (reset_n) begin
            if (ph == 0) begin
               if (a_req || b_req) begin
                  win_a  = a_req && !(RR && b_req && last_a);
                  last_a = win_a;
                  m_we   = win_a ? a_we : b_we;
                  m_addr = win_a ? {5'b0, a_addr} : b_addr;
                  m_din  = win_a ? a_din : b_din;
                  ph     = 1;
               end
            end else if (ph == AC) begin
               if (m_we) mmem[m_addr] = m_din;
               else if (win_a) e_a_dout = mrd(m_addr);
               else e_b_dout = mrd(m_addr);
               ph++;
            end else if (done) begin
               ph = 0;
            end else begin
               ph++;
            end
         end
      end
   end

   task automatic xfer(input bit pa, input bit we, input logic [20:0] addr,
                       input logic [7:0] din, output int lat, output int oe_lo,
                       output int we_lo, output int dq_hi, output int other);
      @(posedge clk_sys); #1;
      if (pa) begin a_req = 1; a_we = we; a_addr = addr[15:0]; a_din = din; end
      else begin b_req = 1; b_we = we; b_addr = addr; b_din = din; end
      lat = -1; oe_lo = 0; we_lo = 0; dq_hi = 0; other = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_sys);
         if (!sram_oe_n) oe_lo++;
         if (!sram_we_n) we_lo++;
         if (sram_dq_oe) dq_hi++;
         if (pa ? b_ack : a_ack) other++;
         if (pa ? a_ack : b_ack) begin lat = n; break; end
      end
      @(posedge clk_sys); #1;
      a_req = 0; b_req = 0;
   endtask

   task automatic collect(input int want, output int got, output int t[4], output bit wa[4]);
      got = 0;
      for (int n = 0; n < 60 && got < want; n++) begin
         @(negedge clk_sys);
         if (a_ack || b_ack) begin t[got] = cyc; wa[got] = a_ack; got++; end
      end
      @(posedge clk_sys); #1;
      a_req = 0; b_req = 0;
   endtask

   initial begin
      int lat, oe_lo, we_lo, dq_hi, other, got, acks;
      int t[4];
      bit wa[4];
      bit exp_arb[4];
      for (int i = 0; i < 4; i++) exp_arb[i] = RR ? (i % 2 == 0) : 1'b1;

      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_sram_a", 32'(sram_a), 32'd0);
      reset_n = 1'b1;

      xfer(1'b1, 1'b0, 21'h001234, 8'h00, lat, oe_lo, we_lo, dq_hi, other);
      chk("a_rd_latency", 32'(lat), 32'(AC + 1));
      chk("a_rd_oe_cycles", 32'(oe_lo), 32'(AC));
      chk("a_rd_dout", 32'(a_dout), 32'h5A);
      chk("a_rd_sram_a", 32'(sram_a), 32'h001234);

      xfer(1'b0, 1'b1, 21'h1F0000, 8'hC3, lat, oe_lo, we_lo, dq_hi, other);
      chk("b_wr_latency", 32'(lat), 32'(AC + 1));
      chk("b_wr_dq_oe_cycles", 32'(dq_hi), 32'(AC));
      chk("b_wr_we_cycles", 32'(we_lo), 32'(AC - 1));
      chk("b_wr_no_a_ack", 32'(other), 32'd0);
      chk("b_wr_mem", 32'(smem[21'h1F0000]), 32'hC3);

      @(posedge clk_sys); #1;
      a_req = 1; a_we = 0; a_addr = 16'h0010;
      b_req = 1; b_we = 0; b_addr = 21'h000020;
      collect(4, got, t, wa);
      chk("arb_count", 32'(got), 32'd4);
      for (int i = 0; i < got; i++) chk("arb_winner_is_a", 32'(wa[i]), 32'(exp_arb[i]));
      for (int i = 1; i < got; i++) chk("arb_spacing", 32'(t[i] - t[i-1]), 32'(AC + 2));

      xfer(1'b1, 1'b0, 21'h00FFFF, 8'h00, lat, oe_lo, we_lo, dq_hi, other);
      chk("base_sram_a", 32'(d2_sram_a), 32'h10FFFF);
      chk("base_a_dout", 32'(a_dout), 32'h77);

      @(posedge clk_sys); #1;
      a_req = 1; a_we = 0; a_addr = 16'h0042;
      collect(3, got, t, wa);
      chk("b2b_count", 32'(got), 32'd3);
      for (int i = 1; i < got; i++) chk("b2b_spacing", 32'(t[i] - t[i-1]), 32'(AC + 2));
      chk("b2b_dout", 32'(a_dout), 32'h99);

      @(posedge clk_sys); #1;
      b_req = 1; b_we = 1; b_addr = 21'h0ABCDE; b_din = 8'h11;
      @(posedge clk_sys); #2;
      chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
      #1 reset_n = 1'b0; b_req = 0;
      #1;
      chk("async_rst_we_n", 32'(sram_we_n), 32'd1);
      chk("async_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      acks = 0;
      repeat (3) begin
         @(negedge clk_sys);
         if (a_ack || b_ack) acks++;
      end
      chk("rst_no_ack", 32'(acks), 32'd0);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      xfer(1'b1, 1'b0, 21'h001234, 8'h00, lat, oe_lo, we_lo, dq_hi, other);
      chk("post_rst_latency", 32'(lat), 32'(AC + 1));
      chk("post_rst_dout", 32'(a_dout), 32'h5A);

      repeat (2) @(posedge clk_sys);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
